debug_tx_arbiter: RTL and testbench
===================================

DEBUG_TX_ARBITER -- requirements
Module: debug_tx_arbiter

Interface
REQ-001 SHALL have parameter HEADER_EN, default 1: when 1, send header byte before each debug word.
REQ-002 SHALL have parameter HDR_TAG, default 5'b10100: upper 5 bits of header byte.
REQ-003 SHALL have port CLK  in  1  clock; all logic rising-edge.
REQ-004 SHALL have port RST  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have port tx_flag  in  1  debug send request, level; held until done_sending seen.
REQ-006 SHALL have port dbg_data  in  32  debug word to send.
REQ-007 SHALL have port dbg_mode  in  3  debug mode code placed in header.
REQ-008 SHALL have port done_sending  out  1  one-cycle pulse at end of debug frame.
REQ-009 SHALL have port con_valid  in  1  console byte valid.
REQ-010 SHALL have port con_byte  in  8  console byte.
REQ-011 SHALL have port con_ready  out  1  console accept; transfer on con_valid&con_ready.
REQ-012 SHALL have port uart_start  out  1  one-cycle start pulse to byte UART.
REQ-013 SHALL have port uart_byte  out  8  byte to UART, stable from start until busy falls.
REQ-014 SHALL have port uart_busy  in  1  UART busy; rises cycle after uart_start, falls when byte sent.
REQ-015 SHALL have port grant_dbg  out  1  high while debug frame in progress.

Function
REQ-016 SHALL use FSM states IDLE, START, HOLD, WAIT, DONE.
REQ-017 IDLE: debug request valid = tx_flag & rearm; console request = con_valid.
REQ-018 IDLE, one request: grant it; both: grant requester opposite to last_grant (round-robin, 1-bit pointer).
REQ-019 con_ready SHALL be combinational: high only in IDLE when console wins arbitration this cycle.
REQ-020 Debug grant: capture dbg_data and dbg_mode into registers, byte counter=0, grant_dbg=1, go START.
REQ-021 Console grant: capture con_byte, counter set to last byte, go START.
REQ-022 Debug frame byte order: header {HDR_TAG, mode} (if HEADER_EN), then data[7:0], [15:8], [23:16], [31:24]; 5 bytes (4 if HEADER_EN=0).
REQ-023 START: uart_start=1 for exactly one cycle with uart_byte valid; go HOLD.
REQ-024 HOLD: ignore uart_busy one cycle; go WAIT.
REQ-025 WAIT: stay while uart_busy=1; on uart_busy=0 then if more bytes, increment counter, go START; else debug frame -> DONE, console -> IDLE.
REQ-026 DONE: done_sending=1 one cycle, rearm=0, go IDLE; last_grant=debug.
REQ-027 Console completion SHALL set last_grant=console; no done_sending for console bytes.
REQ-028 rearm SHALL set when tx_flag sampled 0; prevents re-granting stale tx_flag after done.
REQ-029 tx_flag falling mid-frame SHALL NOT abort; frame completes and done_sending still pulses.
REQ-030 dbg_data/dbg_mode changes after grant SHALL NOT affect frame in progress.
REQ-031 con_valid during a debug frame SHALL wait; con_ready stays 0 until IDLE arbitration.
REQ-032 grant_dbg SHALL fall in same cycle done_sending is high (registered from next-state).
REQ-033 uart_byte SHALL hold last value when idle; no X on outputs.

Reset
REQ-034 RST SHALL immediately force: state IDLE, uart_start=0, uart_byte=0, done_sending=0, grant_dbg=0, counter=0, last_grant=console (debug wins first tie), rearm=1.
REQ-035 RST mid-frame SHALL abandon frame without done_sending; con_ready=0 while RST high.

Verification
REQ-036 tx_flag=1, dbg_mode=3'b001, dbg_data=32'hDEADBEEF, busy model 10 cycles -> uart_byte sequence A1,EF,BE,AD,DE, five start pulses, one done_sending.
REQ-037 tx_flag and con_valid (con_byte=8'h41) asserted same cycle after reset -> debug frame first, then 41; second simultaneous request -> console first.
REQ-038 tx_flag held high 3 cycles after done_sending -> no second frame until tx_flag low one cycle then high.
REQ-039 con_valid=1 with bytes 30,31,32 back-to-back -> three single-byte transfers, con_ready one cycle each, no done_sending.
REQ-040 RST pulsed during third byte of debug frame -> outputs reset values next edge, no done_sending; new tx_flag starts fresh 5-byte frame.
REQ-041 HEADER_EN=0, dbg_data=32'h12345678 -> bytes 78,56,34,12, then done_sending.

Source files
------------

// File: rtl/debug_tx_arbiter.sv
// Shares one byte UART between framed debug words and raw console bytes.
// Round-robin arbitration on ties; debug frames end with a done_sending pulse.
module debug_tx_arbiter #(
   parameter int         HEADER_EN = 1,
   parameter logic [4:0] HDR_TAG   = 5'b10100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        tx_flag,
   input  logic [31:0] dbg_data,
   input  logic [2:0]  dbg_mode,
   output logic        done_sending,
   input  logic        con_valid,
   input  logic [7:0]  con_byte,
   output logic        con_ready,
   output logic        uart_start,
   output logic [7:0]  uart_byte,
   input  logic        uart_busy,
   output logic        grant_dbg
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      HOLD,
      WAIT,
      DONE
   } state_t;

   localparam logic [2:0] LAST = (HEADER_EN != 0) ? 3'd4 : 3'd3;

   state_t      state;
   logic [31:0] data_q;
   logic [2:0]  mode_q;
   logic [2:0]  cnt;
   logic        last_grant;
   logic        rearm;
   logic        dbg_req;
   logic        pick_dbg;
   logic        pick_con;

   // Byte i of a debug frame: optional header, then data LSB first.
   function automatic logic [7:0] byte_sel(
      input logic [31:0] d,
      input logic [2:0]  m,
      input logic [2:0]  i
   );
      logic [1:0] k;
      k = (HEADER_EN != 0) ? i[1:0] - 2'd1 : i[1:0];
      byte_sel = (HEADER_EN != 0 && i == 3'd0) ?
                 {HDR_TAG, m} : d[{k, 3'b000} +: 8];
   endfunction

   // last_grant: 1 = debug finished last, 0 = console finished last.
   always_comb begin
      dbg_req   = tx_flag & rearm;
      pick_dbg  = dbg_req & (~con_valid | ~last_grant);
      pick_con  = con_valid & (~dbg_req | last_grant);
      con_ready = ~RST & (state == IDLE) & pick_con;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         data_q       <= '0;
         mode_q       <= '0;
         cnt          <= '0;
         last_grant   <= 1'b0;
         rearm        <= 1'b1;
         uart_start   <= 1'b0;
         uart_byte    <= '0;
         done_sending <= 1'b0;
         grant_dbg    <= 1'b0;
      end else begin
         uart_start   <= 1'b0;
         done_sending <= 1'b0;
         if (!tx_flag)
            rearm <= 1'b1;
         unique case (state)
            IDLE: begin
               if (pick_dbg) begin
                  data_q     <= dbg_data;
                  mode_q     <= dbg_mode;
                  cnt        <= 3'd0;
                  grant_dbg  <= 1'b1;
                  uart_byte  <= byte_sel(dbg_data, dbg_mode, 3'd0);
                  uart_start <= 1'b1;
                  state      <= START;
               end else if (pick_con) begin
                  cnt        <= LAST;
                  uart_byte  <= con_byte;
                  uart_start <= 1'b1;
                  state      <= START;
               end
            end
            START: state <= HOLD;
            HOLD:  state <= WAIT;
            WAIT: begin
               if (!uart_busy) begin
                  if (cnt != LAST) begin
                     cnt        <= cnt + 3'd1;
                     uart_byte  <= byte_sel(data_q, mode_q, cnt + 3'd1);
                     uart_start <= 1'b1;
                     state      <= START;
                  end else if (grant_dbg) begin
                     grant_dbg    <= 1'b0;
                     done_sending <= 1'b1;
                     state        <= DONE;
                  end else begin
                     last_grant <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            DONE: begin
               // Block a still-high tx_flag until it is seen low again.
               rearm      <= 1'b0;
               last_grant <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_tx_arbiter.sv
// Scoreboard bench for debug_tx_arbiter: expected UART bytes are queued
// when requests are driven and popped on every uart_start.
module tb_debug_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;

   logic        tx_flag = 1'b0;
   logic [31:0] dbg_data = '0;
   logic [2:0]  dbg_mode = '0;
   logic        done_sending;
   logic        con_valid = 1'b0;
   logic [7:0]  con_byte = '0;
   logic        con_ready;
   logic        uart_start;
   logic [7:0]  uart_byte;
   logic        uart_busy = 1'b0;
   logic        grant_dbg;

   logic        tx2 = 1'b0;
   logic [31:0] data2 = '0;
   logic        done2;
   logic        rdy2;
   logic        start2;
   logic [7:0]  byte2;
   logic        busy2 = 1'b0;
   logic        gnt2;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   int dones = 0;
   int rdys = 0;
   int starts2 = 0;
   int dones2 = 0;
   int bcnt = 0;
   int bcnt2 = 0;

   logic [7:0] sb1[$];
   logic [7:0] sb2[$];

   always #5 CLK = ~CLK;

   debug_tx_arbiter dut (
      .CLK(CLK),
      .RST(RST),
      .tx_flag(tx_flag),
      .dbg_data(dbg_data),
      .dbg_mode(dbg_mode),
      .done_sending(done_sending),
      .con_valid(con_valid),
      .con_byte(con_byte),
      .con_ready(con_ready),
      .uart_start(uart_start),
      .uart_byte(uart_byte),
      .uart_busy(uart_busy),
      .grant_dbg(grant_dbg)
   );

   debug_tx_arbiter #(.HEADER_EN(0)) dut2 (
      .CLK(CLK),
      .RST(RST),
      .tx_flag(tx2),
      .dbg_data(data2),
      .dbg_mode(3'd5),
      .done_sending(done2),
      .con_valid(1'b0),
      .con_byte(8'h00),
      .con_ready(rdy2),
      .uart_start(start2),
      .uart_byte(byte2),
      .uart_busy(busy2),
      .grant_dbg(gnt2)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // UART models: busy for 10 cycles after each start pulse.
   always @(negedge CLK) begin
      if (RST) begin
         bcnt = 0;
         uart_busy = 1'b0;
      end else if (uart_start) begin
         bcnt = 10;
         uart_busy = 1'b1;
      end else if (bcnt > 0) begin
         bcnt--;
         uart_busy = (bcnt != 0);
      end
      if (uart_start) begin
         starts++;
         check("u1_pending", sb1.size() != 0, 1);
         if (sb1.size() != 0)
            check("u1_byte", uart_byte, sb1.pop_front());
      end
      if (done_sending) begin
         dones++;
         check("done_gnt", grant_dbg, 0);
      end
      if (con_ready) begin
         rdys++;
         check("rdy_gnt", grant_dbg, 0);
      end
   end

   always @(negedge CLK) begin
      if (RST) begin
         bcnt2 = 0;
         busy2 = 1'b0;
      end else if (start2) begin
         bcnt2 = 10;
         busy2 = 1'b1;
      end else if (bcnt2 > 0) begin
         bcnt2--;
         busy2 = (bcnt2 != 0);
      end
      if (start2) begin
         starts2++;
         check("u2_pending", sb2.size() != 0, 1);
         if (sb2.size() != 0)
            check("u2_byte", byte2, sb2.pop_front());
      end
      if (done2)
         dones2++;
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   function automatic void push_dbg(logic [31:0] d, logic [2:0] m);
      sb1.push_back({5'b10100, m});
      for (int i = 0; i < 4; i++)
         sb1.push_back(d[8*i +: 8]);
   endfunction

   task automatic wait_dones(int target);
      int t = 0;
      while (dones < target && t < 2000) begin
         tick();
         t++;
      end
      check("done_cnt", dones, target);
   endtask

   task automatic dbg_frame(logic [31:0] d, logic [2:0] m);
      int tgt;
      tgt = dones + 1;
      dbg_data = d;
      dbg_mode = m;
      tx_flag = 1'b1;
      wait_dones(tgt);
      tx_flag = 1'b0;
      tick();
   endtask

   task automatic send_con(logic [7:0] b);
      bit hs = 1'b0;
      int t = 0;
      con_valid = 1'b1;
      con_byte = b;
      while (!hs && t < 2000) begin
         @(negedge CLK);
         hs = con_ready;
         @(posedge CLK);
         #1;
         t++;
      end
      con_valid = 1'b0;
      check("con_hs", hs, 1);
   endtask

   task automatic drain();
      int t = 0;
      while ((sb1.size() != 0 || sb2.size() != 0 ||
              bcnt != 0 || bcnt2 != 0) && t < 3000) begin
         tick();
         t++;
      end
      check("drain", sb1.size() + sb2.size(), 0);
      tick(3);
   endtask

   initial begin
      int s0;
      int d0;
      int t;

      // console request during reset must not be accepted
      con_valid = 1'b1;
      con_byte = 8'h55;
      tick(3);
      check("rst_start", uart_start, 0);
      check("rst_byte", uart_byte, 0);
      check("rst_done", done_sending, 0);
      check("rst_gnt", grant_dbg, 0);
      check("rst_rdy", con_ready, 0);
      check("rst_byte2", byte2, 0);
      con_valid = 1'b0;
      RST = 1'b0;
      tick(2);

      // header frame, inputs changed after grant, stale tx_flag
      push_dbg(32'hDEADBEEF, 3'b001);
      dbg_data = 32'hDEADBEEF;
      dbg_mode = 3'b001;
      tx_flag = 1'b1;
      tick(3);
      check("gnt_on", grant_dbg, 1);
      dbg_data = 32'h0;
      dbg_mode = 3'd6;
      wait_dones(1);
      check("starts_f1", starts, 5);
      tick(3);
      check("stale_starts", starts, 5);
      check("stale_gnt", grant_dbg, 0);
      tx_flag = 1'b0;
      tick();

      // rearmed frame; tx_flag dropped mid-frame
      push_dbg(32'h01020304, 3'd7);
      dbg_data = 32'h01020304;
      dbg_mode = 3'd7;
      tx_flag = 1'b1;
      tick(12);
      tx_flag = 1'b0;
      wait_dones(2);
      check("starts_f2", starts, 10);
      tick(2);

      // back-to-back console bytes
      sb1.push_back(8'h30);
      send_con(8'h30);
      sb1.push_back(8'h31);
      send_con(8'h31);
      sb1.push_back(8'h32);
      send_con(8'h32);
      drain();
      check("con_rdys", rdys, 3);
      check("con_dones", dones, 2);
      check("con_starts", starts, 13);
      check("idle_hold", uart_byte, 8'h32);

      // tie after reset: debug first
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tick(2);
      push_dbg(32'hDEADBEEF, 3'b001);
      sb1.push_back(8'h41);
      fork
         dbg_frame(32'hDEADBEEF, 3'b001);
         send_con(8'h41);
      join
      drain();

      // debug alone, then tie: console first
      push_dbg(32'hCAFEF00D, 3'd2);
      dbg_frame(32'hCAFEF00D, 3'd2);
      tick(2);
      sb1.push_back(8'h42);
      push_dbg(32'h0BADC0DE, 3'd3);
      fork
         dbg_frame(32'h0BADC0DE, 3'd3);
         send_con(8'h42);
      join
      drain();

      // reset during third byte
      s0 = starts;
      d0 = dones;
      sb1.push_back(8'hA1);
      sb1.push_back(8'hEF);
      sb1.push_back(8'hBE);
      dbg_data = 32'hDEADBEEF;
      dbg_mode = 3'b001;
      tx_flag = 1'b1;
      t = 0;
      while (starts < s0 + 3 && t < 2000) begin
         tick();
         t++;
      end
      check("third_byte", starts, s0 + 3);
      tick(4);
      RST = 1'b1;
      #1;
      check("mrst_start", uart_start, 0);
      check("mrst_byte", uart_byte, 0);
      check("mrst_gnt", grant_dbg, 0);
      check("mrst_done", done_sending, 0);
      check("mrst_rdy", con_ready, 0);
      tx_flag = 1'b0;
      tick(2);
      RST = 1'b0;
      tick(2);
      check("mrst_nodone", dones, d0);
      push_dbg(32'hDEADBEEF, 3'b001);
      dbg_frame(32'hDEADBEEF, 3'b001);
      check("fresh_starts", starts, s0 + 8);
      drain();

      // no header
      sb2.push_back(8'h78);
      sb2.push_back(8'h56);
      sb2.push_back(8'h34);
      sb2.push_back(8'h12);
      data2 = 32'h12345678;
      tx2 = 1'b1;
      t = 0;
      while (dones2 < 1 && t < 2000) begin
         tick();
         t++;
      end
      tx2 = 1'b0;
      check("nh_done", dones2, 1);
      check("nh_starts", starts2, 4);
      check("nh_gnt", gnt2, 0);
      check("nh_rdy", rdy2, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
